// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response types and the interface bundling them between initiator and responder.
// The master modport drives requests; the slave modport returns responses.
package dbus_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

interface dbus_sram_responder_if;
    import dbus_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_sram_responder.sv
// Data-bus slave backed by a byte-lane 64-bit scratchpad with programmable response latency.
// Define DBUS_SRAM_INIT_EN to zero the whole array word by word after every reset.
module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    dbus_sram_responder_if.slave  dbus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

`ifdef DBUS_SRAM_INIT_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_data_ok;
    logic               w_addr_ok;
    logic               w_accept;
    logic               w_load_resp;
    logic [IDX_W-1:0]   w_req_idx;
    logic               w_mem_we;
    logic [7:0]         w_mem_be;
    logic [IDX_W-1:0]   w_mem_idx;
    logic [63:0]        w_mem_wdata;
    logic [63:0]        w_rd_word;
    logic [63:0]        w_resp_data;
    logic               w_unused_bits;

`ifdef DBUS_SRAM_INIT_EN
    logic [IDX_W-1:0]   r_clr_idx;
`endif

    // Only the word index matters; byte offset, high address bits and size are don't-cares.
    assign w_req_idx     = dbus.dreq.addr[3 +: IDX_W];
    assign w_unused_bits = ^{dbus.dreq.addr[63:3+IDX_W], dbus.dreq.addr[2:0], dbus.dreq.size};

    assign w_addr_ok = (r_state == ST_IDLE) && dbus.dreq.valid;
    assign w_accept  = w_addr_ok && !reset;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load_resp  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_next   = CNT_LOAD;
                    w_state_next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_cnt_next = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = ST_RESP;
                    w_load_resp  = 1'b1;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
`ifdef DBUS_SRAM_INIT_EN
                if (r_clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
                    w_state_next = ST_IDLE;
                end
`else
                w_state_next = ST_IDLE;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RESET_STATE;
            r_cnt     <= '0;
            r_data_ok <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_data_ok <= (w_state_next == ST_RESP);
        end
    end

`ifdef DBUS_SRAM_INIT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr_idx <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_idx <= r_clr_idx + IDX_W'(1);
        end
    end
`endif

    // Single write port shared by request writes and the clear sweep.
    always_comb begin
        w_mem_we    = w_accept && (dbus.dreq.strobe != 8'h00);
        w_mem_be    = dbus.dreq.strobe;
        w_mem_idx   = w_req_idx;
        w_mem_wdata = dbus.dreq.data;
`ifdef DBUS_SRAM_INIT_EN
        if (r_state == ST_CLEAR) begin
            w_mem_we    = !reset;
            w_mem_be    = 8'hFF;
            w_mem_idx   = r_clr_idx;
            w_mem_wdata = '0;
        end
`endif
    end

    // One byte-wide array per lane keeps partial writes a plain RAM write-enable.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH_WORDS];
            logic [7:0] r_rd;

            always_ff @(posedge clk) begin
                if (w_mem_we && w_mem_be[gi]) begin
                    r_mem[w_mem_idx] <= w_mem_wdata[gi*8 +: 8];
                end
            end

            // Read-before-write on the accept edge yields the pre-write word.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_rd <= '0;
                end else if (w_accept) begin
                    r_rd <= r_mem[w_req_idx];
                end
            end

            assign w_rd_word[gi*8 +: 8] = r_rd;
        end
    endgenerate

    // With more than one cycle of latency, re-register so the output only changes entering RESP.
    generate
        if (LATENCY == 1) begin : g_direct
            assign w_resp_data = w_rd_word;
        end else begin : g_staged
            logic [63:0] r_data;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_data <= '0;
                end else if (w_load_resp) begin
                    r_data <= w_rd_word;
                end
            end
            assign w_resp_data = r_data;
        end
    endgenerate

    assign dbus.dresp = '{addr_ok: w_addr_ok, data_ok: r_data_ok, data: w_resp_data};

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder at LATENCY=2, DEPTH_WORDS=512.
// Also exercises the clear sweep when built with DBUS_SRAM_INIT_EN.
module tb_dbus_sram_responder;
    import dbus_pkg::*;

    localparam int DEPTH = 512;
    localparam int LAT   = 2;
`ifdef DBUS_SRAM_INIT_EN
    localparam logic [63:0] EXP_AFTER_RST = 64'h0;
`else
    localparam logic [63:0] EXP_AFTER_RST = 64'h1122_3344_5566_AABB;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] last_resp;
    bit          last_known;
    logic [63:0] b2b_addr [3];
    logic [63:0] b2b_exp  [3];

    dbus_sram_responder_if dbus ();

    dbus_sram_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .dbus  (dbus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
        dbus.dreq = '{valid: v, addr: a, size: 3'd3, strobe: s, data: d};
    endtask

    task automatic post_reset();
`ifdef DBUS_SRAM_INIT_EN
        int n;
        n = 0;
        drive(1'b1, 64'h8, 8'h00, 64'h0);
        #1;
        while (!dbus.dresp.addr_ok && n < DEPTH + 4) begin
            step();
            n++;
        end
        chk("clear_cycles", 64'(n), 64'(DEPTH));
        step();
        chk("clear_busy_dok", 64'(dbus.dresp.data_ok), 64'h0);
        step();
        chk("clear_dok", 64'(dbus.dresp.data_ok), 64'h1);
        chk("clear_data", dbus.dresp.data, 64'h0);
        drive(1'b0, 64'h0, 8'h00, 64'h0);
        step();
        $display("txn clear_sweep cycles=%0d", n);
`endif
        last_resp  = 64'h0;
        last_known = 1'b1;
    endtask

    // Full transaction at LATENCY=2: accept in T, response in T+2, idle in T+3.
    task automatic txn(input string tag, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] d, input bit chkd, input logic [63:0] exp);
        drive(1'b1, a, s, d);
        #1;
        chk({tag, "_aok_T"}, 64'(dbus.dresp.addr_ok), 64'h1);
        chk({tag, "_dok_T"}, 64'(dbus.dresp.data_ok), 64'h0);
        step();
        chk({tag, "_aok_T1"}, 64'(dbus.dresp.addr_ok), 64'h0);
        chk({tag, "_dok_T1"}, 64'(dbus.dresp.data_ok), 64'h0);
        if (last_known) chk({tag, "_hold_T1"}, dbus.dresp.data, last_resp);
        step();
        chk({tag, "_dok_T2"}, 64'(dbus.dresp.data_ok), 64'h1);
        chk({tag, "_aok_T2"}, 64'(dbus.dresp.addr_ok), 64'h0);
        if (chkd) chk({tag, "_data"}, dbus.dresp.data, exp);
        $display("txn %s addr=%h strobe=%h wdata=%h rdata=%h", tag, a, s, d, dbus.dresp.data);
        drive(1'b0, 64'h0, 8'h00, 64'h0);
        step();
        chk({tag, "_dok_T3"}, 64'(dbus.dresp.data_ok), 64'h0);
        if (chkd) chk({tag, "_hold_T3"}, dbus.dresp.data, exp);
        last_resp  = exp;
        last_known = chkd;
    endtask

    initial begin
        b2b_addr[0] = 64'h0;
        b2b_addr[1] = 64'h8;
        b2b_addr[2] = 64'h10;
        b2b_exp[0]  = 64'h0123_4567_89AB_CDEF;
        b2b_exp[1]  = 64'h0000_0000_0000_DEAD;
        b2b_exp[2]  = 64'h5ADC_BA98_7654_3210;

        reset = 1'b1;
        drive(1'b0, 64'h0, 8'h00, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_aok", 64'(dbus.dresp.addr_ok), 64'h0);
        chk("rst_dok", 64'(dbus.dresp.data_ok), 64'h0);
        chk("rst_data", dbus.dresp.data, 64'h0);
        drive(1'b1, 64'h40, 8'h00, 64'h0);
        step();
        chk("rst_dok_valid", 64'(dbus.dresp.data_ok), 64'h0);
        chk("rst_data_valid", dbus.dresp.data, 64'h0);
        drive(1'b0, 64'h0, 8'h00, 64'h0);
        reset = 1'b0;
        post_reset();

        txn("wr_full",  64'h40, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 64'h0);
        txn("rd_full",  64'h40, 8'h00, 64'h0, 1'b1, 64'h1122_3344_5566_7788);
        txn("wr_strb",  64'h40, 8'h03, 64'h0000_0000_0000_AABB, 1'b1, 64'h1122_3344_5566_7788);
        txn("rd_strb",  64'h40, 8'h00, 64'h0, 1'b1, 64'h1122_3344_5566_AABB);
        txn("wr_wrap",  64'h1008, 8'hFF, 64'h0000_0000_0000_DEAD, 1'b0, 64'h0);
        txn("rd_wrap",  64'h0F, 8'h00, 64'h0, 1'b1, 64'h0000_0000_0000_DEAD);
        txn("wr_w0",    64'h0, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0);
        txn("wr_w2",    64'h10, 8'hFF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'h0);
        txn("wr_hi",    64'h10, 8'h80, 64'h5A00_0000_0000_0000, 1'b1, 64'hFEDC_BA98_7654_3210);

        // Back-to-back reads with valid held high throughout.
        drive(1'b1, b2b_addr[0], 8'h00, 64'h0);
        #1;
        for (int c = 0; c < 9; c++) begin
            logic exp_aok;
            logic exp_dok;
            exp_aok = ((c % 3) == 0);
            exp_dok = ((c % 3) == 2);
            chk($sformatf("b2b_aok_c%0d", c), 64'(dbus.dresp.addr_ok), 64'(exp_aok));
            chk($sformatf("b2b_dok_c%0d", c), 64'(dbus.dresp.data_ok), 64'(exp_dok));
            if (exp_dok) begin
                chk($sformatf("b2b_data_%0d", c / 3), dbus.dresp.data, b2b_exp[c / 3]);
                $display("txn b2b_%0d addr=%h rdata=%h", c / 3, dbus.dreq.addr, dbus.dresp.data);
                if (c / 3 < 2) dbus.dreq.addr = b2b_addr[c / 3 + 1];
                else           dbus.dreq.valid = 1'b0;
            end
            step();
        end
        chk("b2b_dok_end", 64'(dbus.dresp.data_ok), 64'h0);
        chk("b2b_aok_end", 64'(dbus.dresp.addr_ok), 64'h0);

        // Reset in BUSY: the accepted read must never respond.
        drive(1'b1, 64'h40, 8'h00, 64'h0);
        #1;
        chk("rstb_aok", 64'(dbus.dresp.addr_ok), 64'h1);
        step();
        reset = 1'b1;
        #1;
        chk("rstb_dok_now", 64'(dbus.dresp.data_ok), 64'h0);
        drive(1'b0, 64'h0, 8'h00, 64'h0);
        step();
        chk("rstb_dok_T2", 64'(dbus.dresp.data_ok), 64'h0);
        reset = 1'b0;
        post_reset();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rstb_quiet_%0d", c), 64'(dbus.dresp.data_ok), 64'h0);
            step();
        end
        $display("txn rst_busy addr=0000000000000040 dropped");
        txn("rd_after_rst", 64'h40, 8'h00, 64'h0, 1'b1, EXP_AFTER_RST);

        // Reset in RESP: data_ok must drop without waiting for a clock edge.
        drive(1'b1, 64'h40, 8'h00, 64'h0);
        step();
        step();
        chk("rstr_dok_pre", 64'(dbus.dresp.data_ok), 64'h1);
        reset = 1'b1;
        #1;
        chk("rstr_dok_now", 64'(dbus.dresp.data_ok), 64'h0);
        chk("rstr_data_now", dbus.dresp.data, 64'h0);
        drive(1'b0, 64'h0, 8'h00, 64'h0);
        step();
        reset = 1'b0;
        post_reset();
        $display("txn rst_resp addr=0000000000000040 dropped");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
